// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: reset/bubble defaults,
// FSM state encoding and the IF/ID entry layout.
package fetch_stage_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT    = 32'h0000_0013;  // addi x0,x0,0
   localparam logic [XLEN-1:0] INSTR_BYTES          = 32'd4;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      HOLD  = 2'd2,
      FLUSH = 2'd3
   } fetch_state_e;

   // One fetched instruction as seen by the decoder.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry skid buffer: parks a response that arrived while IF/ID was locked
// so it can be handed to IF/ID before any new fetch after the hold ends.
module fetch_skid_buffer
   import fetch_stage_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            capture,
   input  logic            drain,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] instr,
   output fetch_entry_t    entry
);

   logic            held;
   logic [XLEN-1:0] held_pc;
   logic [XLEN-1:0] held_instr;

   // Occupancy flag: reset and redirects empty the buffer, capture fills it.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         held <= 1'b0;
      end else if (capture) begin
         held <= 1'b1;
      end else if (drain) begin
         held <= 1'b0;
      end
   end

   // Payload capture.
   // NOTE: the payload is deliberately left out of reset; 'held' qualifies it,
   // so resetting these wide registers would buy nothing.
   always_ff @(posedge clk) begin
      if (capture) begin
         held_pc    <= pc;
         held_instr <= instr;
      end
   end

   assign entry = '{valid: held, pc: held_pc, instr: held_instr};

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, imem request issue and the IF/ID
// pipeline register, steered by the hazard unit lockers and EX redirects.
// Build option: define FETCH_SKID_EN to keep a response that arrives while
// IF/ID is locked in a one-entry skid buffer instead of re-fetching it.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
   parameter logic [XLEN-1:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            PCLocker,
   input  logic            IF_IDLocker,
   input  logic            redirectValid,
   input  logic [XLEN-1:0] redirectPC,
   output logic            imemReqValid,
   output logic [XLEN-1:0] imemReqAddr,
   input  logic            imemRespValid,
   input  logic [XLEN-1:0] imemRespData,
   output logic            ifIdValid,
   output logic [XLEN-1:0] ifIdPC,
   output logic [XLEN-1:0] ifIdInstr,
   output logic [XLEN-1:0] pcOut
);

   fetch_state_e    state;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] resp_pc;      // address requested last cycle = PC of this cycle's response
   logic            req_valid;
   fetch_entry_t    if_id;
   fetch_entry_t    if_id_load;
   fetch_entry_t    resp_entry;
   fetch_entry_t    skid_entry;
   logic [XLEN-1:0] replay_pc;    // PC to resume from once the hold is released
   logic            resp_ok;
   logic            stall;
   logic            redirect_taken;

   // Only RUN consumes responses: FLUSH sees the wrong path, HOLD freezes
   // IF/ID, and BOOT may still see a reply to a pre-reset request.
   assign resp_ok        = imemRespValid && (state == RUN);
   assign resp_entry     = '{valid: 1'b1, pc: resp_pc, instr: imemRespData};
   assign stall          = !PCLocker || !IF_IDLocker;
   assign redirect_taken = redirectValid && (state != BOOT);

`ifdef FETCH_SKID_EN
   logic skid_capture;
   logic skid_drain;

   // A response that IF/ID cannot take is parked; the in-flight request behind
   // it is dropped and re-issued from the unchanged PC.
   assign skid_capture = resp_ok && !IF_IDLocker && !redirect_taken;
   assign skid_drain   = (state == RUN) && IF_IDLocker && skid_entry.valid && !redirect_taken;
   assign replay_pc    = pc;

   fetch_skid_buffer u_skid (
      .clk     (clk),
      .rst     (rst),
      .flush   (redirect_taken),
      .capture (skid_capture),
      .drain   (skid_drain),
      .pc      (resp_pc),
      .instr   (imemRespData),
      .entry   (skid_entry)
   );
`else
   assign skid_entry = '{valid: 1'b0, pc: '0, instr: '0};
   // A response dropped because IF/ID is locked must be fetched again.
   assign replay_pc  = (resp_ok && !IF_IDLocker) ? resp_pc : pc;
`endif

   // Value IF/ID takes when it is allowed to load: parked entry first, then
   // this cycle's response, otherwise a bubble.
   // NOTE: the default assignment first guarantees no latch is inferred.
   always_comb begin
      if_id_load = '{valid: 1'b0, pc: if_id.pc, instr: NOP_INSTR};
      if (skid_entry.valid) begin
         if_id_load = skid_entry;
      end else if (resp_ok) begin
         if_id_load = resp_entry;
      end
   end

   // Fetch FSM with registered PC, request and IF/ID outputs.
   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= BOOT;
         pc        <= RESET_VECTOR;
         req_valid <= 1'b0;
         if_id     <= '{valid: 1'b0, pc: '0, instr: NOP_INSTR};
      end else if (redirect_taken) begin
         state       <= FLUSH;
         pc          <= redirectPC;
         req_valid   <= 1'b1;
         if_id.valid <= 1'b0;
         if_id.instr <= NOP_INSTR;
      end else begin
         case (state)
            BOOT: begin
               state     <= RUN;
               req_valid <= 1'b1;
            end
            RUN, FLUSH: begin
               if (IF_IDLocker) begin
                  if_id <= if_id_load;
               end
               if (stall) begin
                  state     <= HOLD;
                  req_valid <= 1'b0;
                  pc        <= replay_pc;
               end else begin
                  state     <= RUN;
                  req_valid <= 1'b1;
                  pc        <= pc + INSTR_BYTES;
               end
            end
            HOLD: begin
               if (!stall) begin
                  state     <= RUN;
                  req_valid <= 1'b1;
               end
            end
            default: state <= BOOT;
         endcase
      end
   end

   // Remember which address the next response belongs to.
   always_ff @(posedge clk) begin
      if (rst) begin
         resp_pc <= RESET_VECTOR;
      end else begin
         resp_pc <= pc;
      end
   end

   assign imemReqValid = req_valid;
   assign imemReqAddr  = pc;
   assign pcOut        = pc;
   assign ifIdValid    = if_id.valid;
   assign ifIdPC       = if_id.pc;
   assign ifIdInstr    = if_id.instr;

endmodule
